// File: rtl/inst_sram_ctrl.sv
// Instruction-side SRAM read controller with a one-entry fetched-word holding register.
// Misses run a multi-cycle SRAM read; hits return the held word with zero latency.
module inst_sram_ctrl #(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned SRAM_AW     = 20
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        im_addr,
   output logic [31:0]        im_data,
   output logic               fetch_stall,
   output logic               im_fault,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic               sram_ce_n,
   output logic               sram_oe_n,
   output logic               sram_we_n,
   input  logic [31:0]        sram_data
);

   localparam int unsigned CNT_W = 3;

   typedef enum logic {
      IDLE,
      ACCESS
   } state_t;

   state_t            state;
   logic              hold_valid;
   logic [31:0]       hold_addr;
   logic [31:0]       hold_data;
   logic [31:0]       req_addr;
   logic [CNT_W-1:0]  cnt;

   logic idle_req;
   logic fault;
   logic hit;
   logic miss;

   // Request classification; the no-request code takes precedence over the fault check.
   always_comb begin
      idle_req = (im_addr == 32'hFFFF_FFFF);
      fault    = !idle_req && ((im_addr[1:0] != 2'b00) || (im_addr[31:22] != 10'h200));
      hit      = !idle_req && !fault && hold_valid && (im_addr == hold_addr);
      miss     = !idle_req && !fault && !hit;
   end

   assign im_data     = hit ? hold_data : 32'h0;
   assign im_fault    = fault;
   assign fetch_stall = (state == ACCESS) || miss;
   assign sram_we_n   = 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         hold_valid <= 1'b0;
         hold_addr  <= 32'h0;
         hold_data  <= 32'h0;
         req_addr   <= 32'h0;
         cnt        <= '0;
         sram_addr  <= '0;
         sram_ce_n  <= 1'b1;
         sram_oe_n  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (miss) begin
                  req_addr  <= im_addr;
                  sram_addr <= im_addr[SRAM_AW+1:2];
                  sram_ce_n <= 1'b0;
                  sram_oe_n <= 1'b0;
                  cnt       <= CNT_W'(WAIT_CYCLES);
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               // In-flight access always completes, even if fetch has redirected.
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  hold_data  <= sram_data;
                  hold_addr  <= req_addr;
                  hold_valid <= 1'b1;
                  sram_ce_n  <= 1'b1;
                  sram_oe_n  <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_sram_ctrl.sv
// Directed plus randomized bench for inst_sram_ctrl against a fetch-level reference model.
module tb_inst_sram_ctrl;

   localparam int unsigned WAIT_CYCLES = 2;
   localparam int unsigned SRAM_AW     = 20;

   logic               clk = 1'b0;
   logic               rst;
   logic [31:0]        im_addr;
   logic [31:0]        im_data;
   logic               fetch_stall;
   logic               im_fault;
   logic [SRAM_AW-1:0] sram_addr;
   logic               sram_ce_n;
   logic               sram_oe_n;
   logic               sram_we_n;
   logic [31:0]        sram_data;

   int passed = 0;
   int total  = 0;

   // Reference model: what the fetch stage believes is held.
   bit          m_valid = 1'b0;
   logic [31:0] m_addr  = 32'h0;

   always #5 clk = ~clk;

   inst_sram_ctrl #(.WAIT_CYCLES(WAIT_CYCLES), .SRAM_AW(SRAM_AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .im_addr     (im_addr),
      .im_data     (im_data),
      .fetch_stall (fetch_stall),
      .im_fault    (im_fault),
      .sram_addr   (sram_addr),
      .sram_ce_n   (sram_ce_n),
      .sram_oe_n   (sram_oe_n),
      .sram_we_n   (sram_we_n),
      .sram_data   (sram_data)
   );

   function automatic logic [31:0] mem_word(input logic [19:0] w);
      if (w == 20'h0) return 32'h3C08_BFC0;
      return {w[11:0], w} ^ 32'hA5C3_0F11;
   endfunction

   // SRAM only drives meaningful data while output-enabled.
   assign sram_data = sram_oe_n ? 32'hDEAD_BEEF : mem_word(sram_addr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Entered at posedge+1; samples each cycle at the falling edge; leaves at posedge+1.
   task automatic fetch(input logic [31:0] a);
      bit   is_idle, is_fault, is_hit, sa_ok;
      int   st, ce;
      is_idle  = (a == 32'hFFFF_FFFF);
      is_fault = !is_idle && ((a[1:0] != 2'b00) || (a < 32'h8000_0000) || (a > 32'h803F_FFFC));
      is_hit   = !is_idle && !is_fault && m_valid && (a == m_addr);
      im_addr  = a;
      #4;
      if (is_idle || is_fault || is_hit) begin
         check("fault_flag", 32'(im_fault), 32'(is_fault));
         check("no_stall",   32'(fetch_stall), 32'h0);
         check("data",       im_data, is_hit ? mem_word(a[21:2]) : 32'h0);
         check("no_ce",      32'(sram_ce_n), 32'h1);
         @(posedge clk); #1;
      end else begin
         st = 0; ce = 0; sa_ok = 1'b1;
         while (fetch_stall === 1'b1 && st < 40) begin
            st++;
            if (sram_ce_n === 1'b0) begin
               ce++;
               if (sram_addr !== a[21:2] || sram_oe_n !== 1'b0) sa_ok = 1'b0;
            end
            @(posedge clk); #5;
         end
         check("miss_stall_cycles", 32'(st), 32'(WAIT_CYCLES + 2));
         check("miss_ce_cycles",    32'(ce), 32'(WAIT_CYCLES + 1));
         check("miss_sram_addr_ok", 32'(sa_ok), 32'h1);
         check("miss_data",         im_data, mem_word(a[21:2]));
         check("miss_ce_released",  32'(sram_ce_n), 32'h1);
         m_valid = 1'b1;
         m_addr  = a;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int          st, eps, r;
      logic        prev_ce;
      logic [19:0] first_sa, last_sa;
      logic [31:0] a;

      rst     = 1'b1;
      im_addr = 32'hFFFF_FFFF;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #4;
      check("rst_ce_n",      32'(sram_ce_n), 32'h1);
      check("rst_oe_n",      32'(sram_oe_n), 32'h1);
      check("rst_we_n",      32'(sram_we_n), 32'h1);
      check("rst_sram_addr", 32'(sram_addr), 32'h0);
      check("rst_stall",     32'(fetch_stall), 32'h0);
      @(posedge clk); #1;

      repeat (5) fetch(32'hFFFF_FFFF);

      fetch(32'h8000_0000);
      check("word0", im_data, 32'h3C08_BFC0);
      repeat (3) fetch(32'h8000_0000);

      fetch(32'h8000_0002);
      fetch(32'h9000_0000);

      // Redirect while the first access is in flight.
      im_addr = 32'h8000_0004;
      #4;
      st = 0; eps = 0; prev_ce = 1'b1; first_sa = '1; last_sa = '1;
      while (fetch_stall === 1'b1 && st < 60) begin
         st++;
         if (sram_ce_n === 1'b0) begin
            if (prev_ce === 1'b1) begin
               eps++;
               if (eps == 1) first_sa = sram_addr;
            end
            last_sa = sram_addr;
         end
         prev_ce = sram_ce_n;
         @(posedge clk); #1;
         if (st == 2) im_addr = 32'h8000_0100;
         #4;
      end
      check("redir_stall_cycles", 32'(st), 32'(2 * (WAIT_CYCLES + 2)));
      check("redir_episodes",     32'(eps), 32'h2);
      check("redir_first_addr",   32'(first_sa), 32'h1);
      check("redir_second_addr",  32'(last_sa), 32'h40);
      check("redir_data",         im_data, mem_word(20'h40));
      m_valid = 1'b1;
      m_addr  = 32'h8000_0100;
      @(posedge clk); #1;
      fetch(32'h8000_0100);
      fetch(32'h8000_0004);

      // Reset in the middle of an access.
      im_addr = 32'h8000_0200;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #4;
      check("pre_rst_ce_low", 32'(sram_ce_n), 32'h0);
      @(posedge clk); #5;
      check("post_rst_ce_n", 32'(sram_ce_n), 32'h1);
      check("post_rst_oe_n", 32'(sram_oe_n), 32'h1);
      check("post_rst_stall", 32'(fetch_stall), 32'h1);
      @(posedge clk); #1;
      rst     = 1'b0;
      m_valid = 1'b0;
      fetch(32'h8000_0200);

      // Randomized fetch stream against the model.
      a = 32'h8000_0000;
      for (int i = 0; i < 40; i++) begin
         r = int'($urandom_range(0, 9));
         if (r == 0) begin
            fetch(32'hFFFF_FFFF);
         end else if (r == 1) begin
            a = $urandom;
            if (a[31:22] == 10'h200 && a[1:0] == 2'b00) a[0] = 1'b1;
            if (a == 32'hFFFF_FFFF) a = 32'h7FFF_FFFC;
            fetch(a);
         end else if (r <= 4) begin
            fetch(m_valid ? m_addr : 32'h8000_0010);
         end else begin
            a = 32'h8000_0000 | {10'h0, 4'($urandom_range(0, 15)), 12'h0, 4'($urandom_range(0, 3)), 2'b00};
            fetch(a);
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/inst_sram_ctrl.md
# inst_sram_ctrl

Instruction-side SRAM controller sitting directly upstream of the fetch stage: it consumes the fetch stage's `im_addr`, runs a multi-cycle read on the external instruction SRAM, and returns `im_data`. The block holds a one-entry fetched-word register, so repeated reads of the same address are served without an SRAM access. `fetch_stall` is wired to the fetch stage's bubble input, freezing the PC until the word is valid.

## Interface
- `WAIT_CYCLES`, 2: extra SRAM read cycles after the address phase; legal range 0..7.
- `SRAM_AW`, 20: SRAM word-address width; the window is 4 MiB, 0x80000000–0x803FFFFC.
- `clk`  in  1  single clock; every register updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `im_addr`  in  32  byte address from fetch; 0xFFFFFFFF means no request.
- `im_data`  out  32  instruction word; combinational from the held word.
- `fetch_stall`  out  1  high while `im_data` is not yet valid for the current `im_addr`.
- `im_fault`  out  1  current `im_addr` is misaligned or outside the window; combinational.
- `sram_addr`  out  SRAM_AW  registered word address, `im_addr[21:2]`.
- `sram_ce_n`  out  1  registered chip enable, active-low.
- `sram_oe_n`  out  1  registered output enable, active-low.
- `sram_we_n`  out  1  constant 1 (read-only port).
- `sram_data`  in  32  SRAM read data.

## Operation
- Held state: `hold_valid`, `hold_addr[31:0]`, `hold_data[31:0]`, `req_addr[31:0]`, `cnt[2:0]`, and the FSM state.
- Request classification (combinational, every cycle):
  - idle_req: `im_addr == 0xFFFFFFFF`. Gives `im_data = 0`, `fetch_stall = 0`, `im_fault = 0`. No access.
  - fault: `im_addr[1:0] != 0` or `im_addr[31:22] != 10'h200`. Gives `im_fault = 1`, `im_data = 0`, `fetch_stall = 0`. No access.
  - hit: `hold_valid && im_addr == hold_addr`. Gives `im_data = hold_data`, `fetch_stall = 0`.
  - miss: any other address. Gives `fetch_stall = 1` and `im_data = 0`.
- FSM states:
  - IDLE: on a miss, latch `req_addr = im_addr`, drive `sram_addr = im_addr[21:2]`, `sram_ce_n = 0`, `sram_oe_n = 0`, `cnt = WAIT_CYCLES`, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: while `cnt != 0`, decrement `cnt`. When `cnt == 0`:
    - `hold_data = sram_data`, `hold_addr = req_addr`, `hold_valid = 1`;
    - `sram_ce_n = sram_oe_n = 1`;
    - go to IDLE.
- `fetch_stall` stays high throughout ACCESS, regardless of `im_addr`.
- `im_addr` change during ACCESS (e.g. an exception redirect): the in-flight access completes and fills the hold register with `req_addr`. The next IDLE cycle re-classifies `im_addr`; a mismatch starts a new access. Accesses are never aborted mid-cycle.
- Reset values:
  - state IDLE, `hold_valid = 0`, `hold_addr = 0`, `hold_data = 0`, `cnt = 0`;
  - `sram_addr = 0`, `sram_ce_n = 1`, `sram_oe_n = 1`, `sram_we_n = 1`.
  - Combinational outputs follow the classification rules.
- Reset asserted mid-ACCESS: the access is dropped, outputs return to reset values on the next edge, and `hold_valid = 0`, so the next request misses.

## Timing
- Miss detected in cycle T (IDLE). The SRAM address phase is T+1.
- Data is sampled at the end of cycle T+1+WAIT_CYCLES. The hit is visible in T+2+WAIT_CYCLES.
- `fetch_stall` is high for exactly WAIT_CYCLES+2 cycles per miss: 4 at the default, 2 at WAIT_CYCLES = 0.
- Back-to-back sequential fetches: each new PC misses, so steady-state throughput is one instruction per WAIT_CYCLES+3 cycles.
- `sram_ce_n`/`sram_oe_n` are low for exactly WAIT_CYCLES+1 consecutive cycles per access. `sram_addr` is stable across that interval.
- A hit has zero latency: `im_data` follows `im_addr` combinationally in the same cycle.

## Test plan
- Reset, then hold `im_addr = 0xFFFFFFFF` for 5 cycles → `fetch_stall = 0`, `im_data = 0`, `im_fault = 0`, `sram_ce_n = 1` throughout.
- WAIT_CYCLES = 2; drive `im_addr = 0x80000000` with SRAM word 0 = 0x3C08BFC0 → stall high 4 cycles; `sram_addr = 0` with ce/oe low for 3 cycles; then `im_data = 0x3C08BFC0`, stall low.
- Same address held 3 more cycles → no further SRAM activity; `im_data` stable.
- `im_addr = 0x80000002`, then `0x90000000` → `im_fault = 1`, `im_data = 0`, `fetch_stall = 0`, no ce_n pulse.
- Change `im_addr` from 0x80000004 to 0x80000100 during ACCESS → the first access completes; a second access starts at `sram_addr = 0x40`; final `im_data` = word 0x40.
- Assert `rst` during ACCESS → ce_n/oe_n return to 1 on the next edge; re-fetch of the same address misses again (full WAIT_CYCLES+2 stall).
